charmem_dp: RTL and testbench

- Parametrised dual-port character memory for the text-mode display path; successor to the single-port character store.
- Port A is a read-only display port with a fixed 2-cycle pipeline, driven by the pixel/character scanner.
- Port B is a host port with a req/ack handshake for single-character reads and writes.
- An internal clear engine fills the whole array with FILL_CHAR after reset or on request.

---
 rtl/charmem_pkg.sv | 28 ++
 rtl/charmem_ram_dp.sv | 33 +++
 rtl/charmem_dp.sv | 208 ++++++++++++++++++++
 tb/tb_charmem_dp.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/charmem_pkg.sv
// Shared types and helpers for the dual-port character memory: FSM states,
// default fill values and the col/row to linear address mapping.
package charmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CLEAR
  } state_e;

  localparam logic [7:0] FILL_CHAR_DEF = 8'd32;
  localparam logic [7:0] FILL_ATTR_DEF = 8'h07;

  typedef struct packed {
    logic        ok;
    logic [31:0] addr;
  } addr_map_t;

  // Out-of-range coordinates map to address 0 with ok cleared.
  function automatic addr_map_t charmem_map(input int col, input int row,
                                            input int cols, input int rows);
    addr_map_t m;
    m.ok   = (col < cols) && (row < rows);
    m.addr = m.ok ? 32'(row * cols + col) : '0;
    return m;
  endfunction

endpackage

// File: rtl/charmem_ram_dp.sv
// Simple dual-port read-first RAM: port A read/write, port B read-only,
// both with registered read data so the array maps onto block RAM.
module charmem_ram_dp #(
  parameter int DEPTH  = 9600,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem_q[a_addr] <= a_wdata;
      a_rdata <= mem_q[a_addr];
    end
  end

  // A port-A write to the same address in this cycle is not yet visible here.
  always_ff @(posedge clk) begin
    if (b_en) b_rdata <= mem_q[b_addr];
  end

endmodule

// File: rtl/charmem_dp.sv
// Dual-port text-mode character memory: 2-cycle display read port, req/ack
// host port and a clear engine. Define CHARMEM_ATTR_EN for an attribute plane.
module charmem_dp
  import charmem_pkg::*;
#(
  parameter int               COLS      = 160,
  parameter int               ROWS      = 60,
  parameter int               DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(FILL_CHAR_DEF),
  parameter int               COL_W     = $clog2(COLS),
  parameter int               ROW_W     = $clog2(ROWS),
  parameter int               ADDR_W    = $clog2(COLS*ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en,
  input  logic [COL_W-1:0]  disp_col,
  input  logic [ROW_W-1:0]  disp_row,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_char,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [COL_W-1:0]  host_col,
  input  logic [ROW_W-1:0]  host_row,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_req,
  output logic              busy
`ifdef CHARMEM_ATTR_EN
  ,
  input  logic [DATA_W-1:0] host_wattr,
  output logic [DATA_W-1:0] host_rattr,
  output logic [DATA_W-1:0] disp_attr
`endif
);

  localparam int              DEPTH     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_pend_q, clr_pend_d;
  logic              clr_wr;

  addr_map_t         host_map, disp_map;
  logic [ADDR_W-1:0] host_addr_w;
  logic [ADDR_W-1:0] host_addr_q;
  logic              host_ok_q, host_we_q;
  logic [DATA_W-1:0] host_wdata_q;
  logic              host_ack_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_cap;

  logic              ram_a_en, ram_a_we;
  logic [ADDR_W-1:0] ram_a_addr;
  logic [DATA_W-1:0] ram_a_rdata, ram_b_rdata;

  logic              disp_vld_p0_q, disp_ok_p0_q;
  logic [ADDR_W-1:0] disp_addr_p0_q;
  logic              disp_valid_q, disp_ok_p1_q, disp_have_q;

  always_comb begin
    host_map    = charmem_map(int'(host_col), int'(host_row), COLS, ROWS);
    disp_map    = charmem_map(int'(disp_col), int'(disp_row), COLS, ROWS);
    host_addr_w = ADDR_W'(host_map.addr);
  end

  assign host_cap = (state_q == IDLE) && host_req;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = clr_pend_q;
    ram_a_en   = 1'b0;
    ram_a_we   = 1'b0;
    ram_a_addr = host_addr_w;
    clr_wr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Host wins over clear; a simultaneous clear request waits in clr_pend.
        if (host_req) begin
          state_d    = ACCESS;
          ram_a_en   = 1'b1;
          clr_pend_d = clr_pend_q | clr_req;
        end else if (clr_req || clr_pend_q) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          clr_pend_d = 1'b0;
        end
      end
      ACCESS: begin
        ram_a_en   = host_we_q & host_ok_q;
        ram_a_we   = host_we_q & host_ok_q;
        ram_a_addr = host_addr_q;
        clr_pend_d = clr_pend_q | clr_req;
        state_d    = IDLE;
      end
      CLEAR: begin
        ram_a_en   = 1'b1;
        ram_a_we   = 1'b1;
        ram_a_addr = clr_addr_q;
        clr_wr     = 1'b1;
        if (clr_req)                      clr_addr_d = '0;
        else if (clr_addr_q == LAST_ADDR) state_d    = IDLE;
        else                              clr_addr_d = clr_addr_q + 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= CLEAR;
      clr_addr_q    <= '0;
      clr_pend_q    <= 1'b0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= '0;
      disp_vld_p0_q <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_have_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
      host_ack_q <= (state_q == ACCESS);
      if ((state_q == ACCESS) && !host_we_q)
        host_rdata_q <= host_ok_q ? ram_a_rdata : FILL_CHAR;
      disp_vld_p0_q <= disp_en;
      disp_valid_q  <= disp_vld_p0_q;
      if (disp_vld_p0_q) disp_have_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (host_cap) begin
      host_addr_q  <= host_addr_w;
      host_ok_q    <= host_map.ok;
      host_we_q    <= host_we;
      host_wdata_q <= host_wdata;
    end
    // p0: display coordinates registered with disp_en
    disp_addr_p0_q <= ADDR_W'(disp_map.addr);
    disp_ok_p0_q   <= disp_map.ok;
    // p1: memory read; range flag follows the read so disp_char holds with it
    if (disp_vld_p0_q) disp_ok_p1_q <= disp_ok_p0_q;
  end

  charmem_ram_dp #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_char_ram (
    .clk    (clk),
    .a_en   (ram_a_en),
    .a_we   (ram_a_we),
    .a_addr (ram_a_addr),
    .a_wdata(clr_wr ? FILL_CHAR : host_wdata_q),
    .a_rdata(ram_a_rdata),
    .b_en   (disp_vld_p0_q),
    .b_addr (disp_addr_p0_q),
    .b_rdata(ram_b_rdata)
  );

  assign busy       = (state_q == CLEAR);
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_char  = disp_have_q ? (disp_ok_p1_q ? ram_b_rdata : FILL_CHAR) : '0;

`ifdef CHARMEM_ATTR_EN
  localparam logic [DATA_W-1:0] FILL_ATTR = DATA_W'(FILL_ATTR_DEF);

  logic [DATA_W-1:0] host_wattr_q, host_rattr_q;
  logic [DATA_W-1:0] attr_a_rdata, attr_b_rdata;

  always_ff @(posedge clk) begin
    if (host_cap) host_wattr_q <= host_wattr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      host_rattr_q <= '0;
    else if ((state_q == ACCESS) && !host_we_q)
      host_rattr_q <= host_ok_q ? attr_a_rdata : FILL_ATTR;
  end

  charmem_ram_dp #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_attr_ram (
    .clk    (clk),
    .a_en   (ram_a_en),
    .a_we   (ram_a_we),
    .a_addr (ram_a_addr),
    .a_wdata(clr_wr ? FILL_ATTR : host_wattr_q),
    .a_rdata(attr_a_rdata),
    .b_en   (disp_vld_p0_q),
    .b_addr (disp_addr_p0_q),
    .b_rdata(attr_b_rdata)
  );

  assign host_rattr = host_rattr_q;
  assign disp_attr  = disp_have_q ? (disp_ok_p1_q ? attr_b_rdata : FILL_ATTR) : '0;
`endif

endmodule

// File: tb/tb_charmem_dp.sv
// Directed testbench for charmem_dp (default build, no attribute plane).
module tb_charmem_dp;

  localparam int COL_W  = 8;
  localparam int ROW_W  = 6;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_en;
  logic [COL_W-1:0]  disp_col;
  logic [ROW_W-1:0]  disp_row;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_char;
  logic              host_req;
  logic              host_we;
  logic [COL_W-1:0]  host_col;
  logic [ROW_W-1:0]  host_row;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              clr_req;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  charmem_dp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_en   (disp_en),
    .disp_col  (disp_col),
    .disp_row  (disp_row),
    .disp_valid(disp_valid),
    .disp_char (disp_char),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_col  (host_col),
    .host_row  (host_row),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic disp_read(input int col, input int row, input logic [7:0] exp, input string tag);
    disp_en  = 1'b1;
    disp_col = COL_W'(col);
    disp_row = ROW_W'(row);
    step;
    disp_en = 1'b0;
    chk({tag, "_lat"}, 32'(disp_valid), 32'd0);
    step;
    chk({tag, "_vld"}, 32'(disp_valid), 32'd1);
    chk(tag, 32'(disp_char), 32'(exp));
    step;
    chk({tag, "_vld_off"}, 32'(disp_valid), 32'd0);
    chk({tag, "_hold"}, 32'(disp_char), 32'(exp));
  endtask

  task automatic host_op(input logic we, input int col, input int row,
                         input logic [7:0] wd, input logic [7:0] exp, input string tag);
    host_req   = 1'b1;
    host_we    = we;
    host_col   = COL_W'(col);
    host_row   = ROW_W'(row);
    host_wdata = wd;
    step;
    chk({tag, "_ack_early"}, 32'(host_ack), 32'd0);
    step;
    chk({tag, "_ack"}, 32'(host_ack), 32'd1);
    if (!we) chk({tag, "_rdata"}, 32'(host_rdata), 32'(exp));
    host_req = 1'b0;
    step;
    chk({tag, "_ack_pulse"}, 32'(host_ack), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic sawack;

    rst_n = 1'b0; disp_en = 1'b0; disp_col = '0; disp_row = '0;
    host_req = 1'b0; host_we = 1'b0; host_col = '0; host_row = '0;
    host_wdata = '0; clr_req = 1'b0;

    // Reset state
    repeat (3) step;
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_char", 32'(disp_char), 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);

    // Power-up clear: busy for exactly 9600 cycles
    rst_n = 1'b1;
    chk("busy_after_rst", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 20000) begin
      step;
      n++;
    end
    chk("clear_len", 32'(n), 32'd9600);

    disp_read(0, 0, 8'd32, "disp_0_0");
    disp_read(159, 59, 8'd32, "disp_159_59");
    disp_read(80, 30, 8'd32, "disp_80_30");

    // Host write then read back, display at linear address 325
    host_op(1'b1, 5, 2, 8'h48, 8'h00, "hw_5_2");
    host_op(1'b0, 5, 2, 8'h00, 8'h48, "hr_5_2");
    disp_read(5, 2, 8'h48, "disp_5_2");

    // Out-of-range accesses
    host_op(1'b1, 160, 0, 8'h55, 8'h00, "hw_oor_col");
    host_op(1'b1, 0, 60, 8'h66, 8'h00, "hw_oor_row");
    host_op(1'b0, 160, 0, 8'h00, 8'd32, "hr_oor_col");
    disp_read(0, 1, 8'd32, "disp_0_1_untouched");
    disp_read(0, 60, 8'd32, "disp_oor_row");

    // Same-cycle display read and host write: display sees old data
    disp_en = 1'b1; disp_col = 8'd3; disp_row = 6'd3;
    host_req = 1'b1; host_we = 1'b1; host_col = 8'd3; host_row = 6'd3; host_wdata = 8'h41;
    step;
    disp_en = 1'b0;
    chk("coll_ack_early", 32'(host_ack), 32'd0);
    step;
    chk("coll_ack", 32'(host_ack), 32'd1);
    chk("coll_vld", 32'(disp_valid), 32'd1);
    chk("coll_old", 32'(disp_char), 32'd32);
    host_req = 1'b0;
    step;
    disp_read(3, 3, 8'h41, "disp_3_3_new");

    // Clear on request; host read stalled; restart at cycle 100
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    host_req = 1'b1; host_we = 1'b0; host_col = 8'd5; host_row = 6'd2;
    sawack = 1'b0;
    repeat (98) begin
      step;
      sawack |= host_ack;
    end
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    sawack |= host_ack;
    n = 0;
    while (busy && n < 20000) begin
      step;
      n++;
      sawack |= host_ack;
    end
    chk("restart_len", 32'(n), 32'd9600);
    chk("stall_no_ack", 32'(sawack), 32'd0);
    step;
    chk("stall_ack_early", 32'(host_ack), 32'd0);
    step;
    chk("stall_ack", 32'(host_ack), 32'd1);
    chk("stall_rdata", 32'(host_rdata), 32'd32);
    host_req = 1'b0;
    step;
    chk("stall_ack_pulse", 32'(host_ack), 32'd0);

    // Simultaneous host_req and clr_req: access first, clear afterwards
    host_req = 1'b1; host_we = 1'b1; host_col = 8'd7; host_row = 6'd7; host_wdata = 8'h99;
    clr_req = 1'b1;
    step;
    clr_req = 1'b0;
    chk("pend_busy0", 32'(busy), 32'd0);
    step;
    chk("pend_ack", 32'(host_ack), 32'd1);
    host_req = 1'b0;
    step;
    chk("pend_busy1", 32'(busy), 32'd1);

    // Back-to-back display reads with a reset pulse in the middle
    disp_col = 8'd0; disp_row = 6'd0;
    for (int i = 0; i < 200; i++) begin
      disp_en = 1'b1;
      if (i == 100) rst_n = 1'b0;
      if (i == 101) rst_n = 1'b1;
      step;
      if (i == 99) begin
        chk("strm_pre_vld", 32'(disp_valid), 32'd1);
        chk("strm_pre_char", 32'(disp_char), 32'd32);
      end
      if (i == 100) begin
        chk("strm_rst_vld", 32'(disp_valid), 32'd0);
        chk("strm_rst_char", 32'(disp_char), 32'd0);
        chk("strm_rst_busy", 32'(busy), 32'd1);
      end
      if (i == 101) chk("strm_rel_vld", 32'(disp_valid), 32'd0);
      if (i == 102) begin
        chk("strm_resume_vld", 32'(disp_valid), 32'd1);
        chk("strm_resume_char", 32'(disp_char), 32'd32);
      end
      if (i == 199) chk("strm_end_vld", 32'(disp_valid), 32'd1);
    end
    disp_en = 1'b0;
    step;
    chk("strm_drain1", 32'(disp_valid), 32'd1);
    step;
    chk("strm_drain2", 32'(disp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
